// File: rtl/hcsr04_echo_emulator_if.sv
// ---------------------------------------------------------------------------
// hcsr04_echo_emulator_if
//
// Purpose: bundles the sensor-side signals exchanged between a distance
// measurement block and the HC-SR04 echo emulator.
//
// Signals:
//   trigger  - trigger pulse from the measurement block (asynchronous)
//   echo_len - requested echo width in clock cycles
//   echo     - echo pulse returned to the measurement block
//   trig_ok  - one-cycle pulse when a trigger is accepted
//   done     - one-cycle pulse on the echo falling edge
//   busy     - emulator is not idle
//
// Modports:
//   master - the measurement block (drives trigger/echo_len)
//   slave  - the emulator (drives echo/trig_ok/done/busy)
// ---------------------------------------------------------------------------
interface hcsr04_echo_emulator_if;
  logic        trigger;
  logic [31:0] echo_len;
  logic        echo;
  logic        trig_ok;
  logic        done;
  logic        busy;

  modport master (
    output trigger,
    output echo_len,
    input  echo,
    input  trig_ok,
    input  done,
    input  busy
  );

  modport slave (
    input  trigger,
    input  echo_len,
    output echo,
    output trig_ok,
    output done,
    output busy
  );
endinterface

// File: rtl/hcsr04_echo_emulator.sv
// ---------------------------------------------------------------------------
// hcsr04_echo_emulator
//
// Purpose: device-side model of the HC-SR04 ultrasonic sensor. A trigger of
// sufficient width is answered, after the burst delay, with an echo pulse of
// the programmed length (clamped to the no-object timeout). An optional
// hold-off period follows each echo before a new trigger is accepted.
//
// Ports:
//   clk    - single clock
//   rst    - asynchronous, active-high reset
//   sensor - hcsr04_echo_emulator_if.slave (trigger, echo_len in;
//            echo, trig_ok, done, busy out, all registered)
//
// Configuration macro:
//   HCSR04_HOLDOFF_EN - when defined, a HOLDOFF state of HOLDOFF_CYC cycles
//                       follows every echo. When undefined, ECHO returns
//                       straight to IDLE and HOLDOFF_CYC is unused.
// ---------------------------------------------------------------------------
module hcsr04_echo_emulator #(
  parameter int unsigned TRIG_MIN_CYC  = 500,
  parameter int unsigned BURST_DLY_CYC = 10000,
  parameter int unsigned TIMEOUT_CYC   = 1900000,
  parameter int unsigned HOLDOFF_CYC   = 3000000
) (
  input logic                   clk,
  input logic                   rst,
  hcsr04_echo_emulator_if.slave sensor
);

  localparam logic [31:0] TRIG_MIN  = TRIG_MIN_CYC;
  localparam logic [31:0] BURST_DLY = BURST_DLY_CYC;
  localparam logic [31:0] TIMEOUT   = TIMEOUT_CYC;

  // Every count parameter must be at least 1; a zero would make a state
  // complete on the wrong cycle, so refuse to elaborate instead.
  generate
    if (TRIG_MIN_CYC == 0 || BURST_DLY_CYC == 0 || TIMEOUT_CYC == 0 ||
        HOLDOFF_CYC == 0) begin : g_param_check
      $error("hcsr04_echo_emulator: all cycle parameters must be >= 1");
    end
  endgenerate

`ifdef HCSR04_HOLDOFF_EN
  localparam logic [31:0] HOLDOFF = HOLDOFF_CYC;

  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO,
    HOLDOFF_ST
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE,
    TRIG_HI,
    BURST,
    ECHO
  } state_t;
`endif

  state_t      state;
  state_t      state_next;
  logic        trig_m;
  logic        trig_s;
  logic        trig_q;
  logic [31:0] cnt;
  logic [31:0] cnt_next;
  logic [31:0] len;
  logic [31:0] len_next;
  logic [31:0] eff_len;
  logic        echo_r;
  logic        echo_next;
  logic        trig_ok_r;
  logic        trig_ok_next;
  logic        done_r;
  logic        done_next;
  logic        busy_r;
  logic        busy_next;

  // Two-flop synchronizer for the asynchronous trigger, plus one more stage
  // (trig_q) so the IDLE state can detect a genuine rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_m <= 1'b0;
      trig_s <= 1'b0;
      trig_q <= 1'b0;
    end else begin
      trig_m <= sensor.trigger;
      trig_s <= trig_m;
      trig_q <= trig_s;
    end
  end

  // A zero request or one beyond the sensor's range both produce the
  // no-object pulse.
  always_comb begin
    eff_len = sensor.echo_len;
    if ((sensor.echo_len == 32'd0) || (sensor.echo_len > TIMEOUT)) begin
      eff_len = TIMEOUT;
    end
  end

  // Next-state logic. The shared counter always holds the index of the
  // current cycle within a state (starting at 1), so a state lasting N
  // cycles ends on the edge where the counter reads N. Outputs are computed
  // here as next values and registered below, which keeps every output
  // free of combinational input paths.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    len_next     = len;
    echo_next    = echo_r;
    trig_ok_next = 1'b0;
    done_next    = 1'b0;

    unique case (state)
      IDLE: begin
        if (trig_s && !trig_q) begin
          state_next = TRIG_HI;
          cnt_next   = 32'd1;
        end
      end

      TRIG_HI: begin
        if (trig_s) begin
          // Saturate so arbitrarily long triggers cannot wrap the counter.
          if (cnt < TRIG_MIN) begin
            cnt_next = cnt + 32'd1;
          end
        end else if (cnt >= TRIG_MIN) begin
          state_next   = BURST;
          cnt_next     = 32'd1;
          len_next     = eff_len;
          trig_ok_next = 1'b1;
        end else begin
          state_next = IDLE;
          cnt_next   = 32'd0;
        end
      end

      BURST: begin
        if (cnt >= BURST_DLY) begin
          state_next = ECHO;
          cnt_next   = 32'd1;
          echo_next  = 1'b1;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end

      ECHO: begin
        if (cnt >= len) begin
          echo_next = 1'b0;
          done_next = 1'b1;
`ifdef HCSR04_HOLDOFF_EN
          state_next = HOLDOFF_ST;
          cnt_next   = 32'd1;
`else
          state_next = IDLE;
          cnt_next   = 32'd0;
`endif
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end

`ifdef HCSR04_HOLDOFF_EN
      HOLDOFF_ST: begin
        if (cnt >= HOLDOFF) begin
          state_next = IDLE;
          cnt_next   = 32'd0;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
`endif

      default: begin
        state_next = IDLE;
        cnt_next   = 32'd0;
        echo_next  = 1'b0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  // State, counter, latched length and registered outputs. Reset clears
  // everything at once, which drops an echo in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 32'd0;
      len       <= 32'd0;
      echo_r    <= 1'b0;
      trig_ok_r <= 1'b0;
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      len       <= len_next;
      echo_r    <= echo_next;
      trig_ok_r <= trig_ok_next;
      done_r    <= done_next;
      busy_r    <= busy_next;
    end
  end

  assign sensor.echo    = echo_r;
  assign sensor.trig_ok = trig_ok_r;
  assign sensor.done    = done_r;
  assign sensor.busy    = busy_r;

endmodule

// File: tb/tb_hcsr04_echo_emulator.sv
// ---------------------------------------------------------------------------
// tb_hcsr04_echo_emulator
//
// Self-checking bench for hcsr04_echo_emulator with shortened timing
// parameters. A transaction-level reference model predicts, for every
// trigger pulse, the cycle numbers of trig_ok, echo rise/fall, done and the
// busy edges; a monitor records the cycles where the DUT actually produced
// those events and the two lists are compared.
// ---------------------------------------------------------------------------
module tb_hcsr04_echo_emulator;

  localparam int unsigned MIN_W   = 8;
  localparam int unsigned BURST   = 20;
  localparam int unsigned TIMEOUT = 60;
  localparam int unsigned HOLD    = 30;
`ifdef HCSR04_HOLDOFF_EN
  localparam longint HOLD_EFF = HOLD;
`else
  localparam longint HOLD_EFF = 0;
`endif

  logic   clk;
  logic   rst;
  longint cyc;

  hcsr04_echo_emulator_if sensor_bus ();

  hcsr04_echo_emulator #(
    .TRIG_MIN_CYC (MIN_W),
    .BURST_DLY_CYC(BURST),
    .TIMEOUT_CYC  (TIMEOUT),
    .HOLDOFF_CYC  (HOLD)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .sensor(sensor_bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Observed event cycles (from the monitor) and expected ones (from the model)
  longint obs_ok[$],    exp_ok[$];
  longint obs_rise[$],  exp_rise[$];
  longint obs_fall[$],  exp_fall[$];
  longint obs_done[$],  exp_done[$];
  longint obs_brise[$], exp_brise[$];
  longint obs_bfall[$], exp_bfall[$];

  // Model state: last cycle on which the emulator is still busy
  longint busy_until = 0;
  longint last_rise  = 0;
  longint last_len   = 0;

  // Free-running clock and an edge counter used as the time base
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Safety net so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: sample half a cycle after each edge and log event cycles
  logic prev_echo = 1'b0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (sensor_bus.trig_ok) obs_ok.push_back(cyc);
    if (sensor_bus.done)    obs_done.push_back(cyc);
    if (sensor_bus.echo && !prev_echo) obs_rise.push_back(cyc);
    if (!sensor_bus.echo && prev_echo) obs_fall.push_back(cyc);
    if (sensor_bus.busy && !prev_busy) obs_brise.push_back(cyc);
    if (!sensor_bus.busy && prev_busy) obs_bfall.push_back(cyc);
    prev_echo = sensor_bus.echo;
    prev_busy = sensor_bus.busy;
  end

  // The single comparison point of the bench
  task automatic checkOutput(input string tag, input longint observed,
                             input longint expected);
    n_cmp++;
    if (observed !== expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic longint effLen(input logic [31:0] req);
    if (req == 0 || req > TIMEOUT) return TIMEOUT;
    return req;
  endfunction

  // Reference model of one trigger pulse that goes high just after edge c
  // and stays high for w cycles. With two synchronizer stages the DUT sees
  // the rising edge at edge c+3 and the falling edge (acceptance) at c+w+3.
  task automatic modelPulse(input longint c, input int unsigned w,
                            input logic [31:0] req);
    longint t0;
    longint l;
    if (c + 3 <= busy_until) return;
    t0 = c + w + 3;
    exp_brise.push_back(c + 3);
    if (w >= MIN_W) begin
      l = effLen(req);
      exp_ok.push_back(t0);
      exp_rise.push_back(t0 + BURST);
      exp_fall.push_back(t0 + BURST + l);
      exp_done.push_back(t0 + BURST + l);
      exp_bfall.push_back(t0 + BURST + l + HOLD_EFF);
      busy_until = t0 + BURST + l + HOLD_EFF;
      last_rise  = t0 + BURST;
      last_len   = l;
    end else begin
      exp_bfall.push_back(t0);
      busy_until = t0;
    end
  endtask

  // Called just after a clock edge; leaves the bench just after an edge
  task automatic applyStimulus(input int unsigned w, input logic [31:0] req);
    longint c;
    c = cyc;
    sensor_bus.echo_len = req;
    sensor_bus.trigger  = 1'b1;
    modelPulse(c, w, req);
    repeat (w) @(posedge clk);
    #1;
    sensor_bus.trigger = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  // Advance to just after edge 'target', scrambling echo_len on the way
  task automatic waitUntil(input longint target);
    int guard;
    guard = 0;
    while (cyc < target && guard < 50000) begin
      @(posedge clk);
      #1;
      sensor_bus.echo_len = $urandom;
      guard++;
    end
  endtask

  task automatic compareQueues(input string tag, input longint obs[$],
                               input longint expv[$]);
    int n;
    checkOutput({tag, " count"}, obs.size(), expv.size());
    n = (obs.size() < expv.size()) ? obs.size() : expv.size();
    for (int i = 0; i < n; i++)
      checkOutput($sformatf("%s[%0d]", tag, i), obs[i], expv[i]);
  endtask

  task automatic flushAll();
    obs_ok.delete();    exp_ok.delete();
    obs_rise.delete();  exp_rise.delete();
    obs_fall.delete();  exp_fall.delete();
    obs_done.delete();  exp_done.delete();
    obs_brise.delete(); exp_brise.delete();
    obs_bfall.delete(); exp_bfall.delete();
  endtask

  task automatic checkPhase(input string tag);
    waitUntil(busy_until + 3);
    compareQueues({tag, " trig_ok"},   obs_ok,    exp_ok);
    compareQueues({tag, " echo_rise"}, obs_rise,  exp_rise);
    compareQueues({tag, " echo_fall"}, obs_fall,  exp_fall);
    compareQueues({tag, " done"},      obs_done,  exp_done);
    compareQueues({tag, " busy_rise"}, obs_brise, exp_brise);
    compareQueues({tag, " busy_fall"}, obs_bfall, exp_bfall);
    flushAll();
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, " echo"},    sensor_bus.echo,    0);
    checkOutput({tag, " trig_ok"}, sensor_bus.trig_ok, 0);
    checkOutput({tag, " done"},    sensor_bus.done,    0);
    checkOutput({tag, " busy"},    sensor_bus.busy,    0);
  endtask

  initial begin
    logic [31:0] req;
    int unsigned w;

    rst                 = 1'b1;
    sensor_bus.trigger  = 1'b0;
    sensor_bus.echo_len = 32'd0;
    repeat (3) @(posedge clk);
    #2;
    checkQuiet("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    busy_until = cyc;
    waitUntil(cyc + 3);

    // Nominal, minimum-width trigger
    applyStimulus(MIN_W, 32'd29);
    checkPhase("nominal");

    // Runt trigger, then a valid one straight after
    applyStimulus(MIN_W - 1, 32'd10);
    applyStimulus(MIN_W, 32'd12);
    checkPhase("runt");

    // Length clamping and boundaries
    applyStimulus(MIN_W, 32'd0);
    waitUntil(busy_until + 2);
    applyStimulus(MIN_W + 5, TIMEOUT + 1);
    waitUntil(busy_until + 2);
    applyStimulus(MIN_W, TIMEOUT);
    waitUntil(busy_until + 2);
    applyStimulus(MIN_W, 32'd1);
    checkPhase("clamp");

    // Triggers during ECHO and just after it (HOLDOFF when compiled in),
    // then a trigger rising on the first cycle the emulator is idle again
    applyStimulus(MIN_W, 32'd0);
    waitUntil(last_rise + 5);
    applyStimulus(MIN_W, 32'd3);
    waitUntil(last_rise + last_len + 3);
    applyStimulus(MIN_W, 32'd4);
    waitUntil(busy_until - 2);
    applyStimulus(MIN_W, 32'd17);
    checkPhase("overlap");

    // Reset in the middle of an echo
    applyStimulus(MIN_W, 32'd40);
    waitUntil(last_rise + last_len / 2);
    #2;
    rst = 1'b1;
    #1;
    checkQuiet("mid_reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    flushAll();
    busy_until = cyc;
    waitUntil(cyc + 3);
    applyStimulus(MIN_W, 32'd33);
    checkPhase("after_reset");

    // Randomized trigger widths, lengths and start times
    for (int k = 0; k < 24; k++) begin
      w = $urandom_range(MIN_W + 4, MIN_W - 3);
      case ($urandom_range(0, 4))
        0:       req = 32'd0;
        1:       req = TIMEOUT + 1 + $urandom_range(0, 1000);
        2:       req = TIMEOUT;
        3:       req = 32'd1;
        default: req = $urandom_range(1, TIMEOUT);
      endcase
      if ($urandom_range(0, 2) == 0)
        waitUntil(cyc + $urandom_range(0, 40));
      else
        waitUntil(busy_until - 2 + $urandom_range(0, 5));
      applyStimulus(w, req);
    end
    checkPhase("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
